pc_sequencer: RTL and testbench

Program-counter sequencer for the single-cycle CPU.
- Holds the PC and decodes the fetched instruction's branch opcodes into the J/BEQ/BNEQ strobes consumed by the branch decision logic.
- Takes that logic's TAKEN result back to select the next PC.
- Stalls on memory BUSYWAIT, stops on a HALT opcode, and counts taken redirects for performance monitoring.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_target_adder.sv | 17 +
 rtl/pc_sequencer.sv | 87 ++++++++
 tb/tb_pc_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Opcodes and sequencer state encoding shared by the control unit and the PC sequencer.
package cpu_pkg;

  localparam logic [7:0] OP_J    = 8'h06;
  localparam logic [7:0] OP_BEQ  = 8'h07;
  localparam logic [7:0] OP_BNE  = 8'h0A;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Combinational PC+4 and branch target (PC+4 + sign-extended word offset); wraps modulo 2^PC_W.
module pc_target_adder #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] offset_bytes;

  assign offset_bytes = {{(PC_W-10){offset[7]}}, offset, 2'b00};
  assign pc_plus4     = pc + {{(PC_W-3){1'b0}}, 3'b100};
  assign target       = pc_plus4 + offset_bytes;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, RUN/STALL/HALT sequencing, branch strobe decode and saturating redirect counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              BUSYWAIT,
  input  logic              TAKEN,
  output logic              J,
  output logic              BEQ,
  output logic              BNEQ,
  output logic [PC_W-1:0]   PC,
  output logic              HALTED,
  output logic [CNT_W-1:0]  BRANCH_COUNT
);

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      opcode;
  logic            strobe_en;
  logic            redirect;
  logic            pc_load;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target;

  assign opcode = INSTRUCTION[31:24];

  pc_target_adder #(.PC_W(PC_W)) u_adder (
    .pc       (PC),
    .offset   (INSTRUCTION[23:16]),
    .pc_plus4 (pc_plus4),
    .target   (target)
  );

  always_comb begin
    state_nxt = state;
    strobe_en = 1'b0;
    pc_load   = 1'b0;
    case (state)
      RUN: begin
        if (BUSYWAIT) begin
          state_nxt = STALL;
        end else if (opcode == OP_HALT) begin
          state_nxt = HALT;
        end else begin
          strobe_en = 1'b1;
          pc_load   = 1'b1;
        end
      end
      // Leaving STALL holds PC so the instruction is decoded afresh in RUN.
      STALL: begin
        if (!BUSYWAIT) state_nxt = RUN;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // Strobes never look at TAKEN, keeping the external decision path loop-free.
  assign J        = strobe_en && (opcode == OP_J);
  assign BEQ      = strobe_en && (opcode == OP_BEQ);
  assign BNEQ     = strobe_en && (opcode == OP_BNE);
  assign redirect = TAKEN && (J || BEQ || BNEQ);
  assign HALTED   = (state == HALT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= RUN;
      PC           <= RESET_PC;
      BRANCH_COUNT <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load) begin
        PC <= redirect ? target : pc_plus4;
      end
      if (redirect && (BRANCH_COUNT != {CNT_W{1'b1}})) begin
        BRANCH_COUNT <= BRANCH_COUNT + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; counter narrowed to 8 bits so saturation is reachable quickly.
module tb_pc_sequencer;

  localparam int CNT_W = 8;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_J    = 8'h06;
  localparam logic [7:0] OP_BEQ  = 8'h07;
  localparam logic [7:0] OP_BNE  = 8'h0A;
  localparam logic [7:0] OP_HALT = 8'hFF;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [31:0]      INSTRUCTION;
  logic             BUSYWAIT;
  logic             TAKEN;
  logic             J, BEQ, BNEQ;
  logic [31:0]      PC;
  logic             HALTED;
  logic [CNT_W-1:0] BRANCH_COUNT;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .TAKEN        (TAKEN),
    .J            (J),
    .BEQ          (BEQ),
    .BNEQ         (BNEQ),
    .PC           (PC),
    .HALTED       (HALTED),
    .BRANCH_COUNT (BRANCH_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] off);
    return {op, off, 16'h0000};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_strobes(input string tag, input logic ej, input logic eb, input logic en);
    #1;
    check({tag, ".J"},    32'(J),    32'(ej));
    check({tag, ".BEQ"},  32'(BEQ),  32'(eb));
    check({tag, ".BNEQ"}, 32'(BNEQ), 32'(en));
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    RESET       = 1'b1;
    INSTRUCTION = ins(OP_NOP, 8'h00);
    BUSYWAIT    = 1'b0;
    TAKEN       = 1'b0;
    step();
    step();
    RESET = 1'b0;
    check("rst_pc",     PC,                  32'h0);
    check("rst_halted", 32'(HALTED),         32'h0);
    check("rst_count",  32'(BRANCH_COUNT),   32'h0);

    // Straight-line execution
    for (int i = 0; i < 10; i++) begin
      check("seq_pc", PC, 32'(4 * i));
      check_strobes("seq", 1'b0, 1'b0, 1'b0);
      step();
    end
    check("seq_pc_end", PC, 32'd40);
    check("seq_count",  32'(BRANCH_COUNT), 32'h0);

    // BEQ taken at PC=8: 8+4+3*4 = 24
    do_reset();
    step(); step();
    check("beq_pc0", PC, 32'd8);
    INSTRUCTION = ins(OP_BEQ, 8'h03);
    TAKEN = 1'b1;
    check_strobes("beq", 1'b0, 1'b1, 1'b0);
    step();
    check("beq_taken_pc", PC, 32'd24);
    check("beq_count",    32'(BRANCH_COUNT), 32'd1);

    // BEQ not taken at PC=8
    do_reset();
    INSTRUCTION = ins(OP_NOP, 8'h00);
    TAKEN = 1'b0;
    step(); step();
    INSTRUCTION = ins(OP_BEQ, 8'h03);
    step();
    check("beq_nt_pc",    PC, 32'd12);
    check("beq_nt_count", 32'(BRANCH_COUNT), 32'd0);

    // Backward jump at PC=16: 16+4-8 = 12
    INSTRUCTION = ins(OP_NOP, 8'h00);
    step();
    check("j_pc0", PC, 32'd16);
    INSTRUCTION = ins(OP_J, 8'hFE);
    TAKEN = 1'b1;
    check_strobes("j", 1'b1, 1'b0, 1'b0);
    step();
    check("j_back_pc", PC, 32'd12);
    check("j_count",   32'(BRANCH_COUNT), 32'd1);

    // Self-loop: PC stays, count increments each cycle, then saturates
    INSTRUCTION = ins(OP_NOP, 8'h00);
    step();
    INSTRUCTION = ins(OP_J, 8'hFF);
    for (int i = 0; i < 4; i++) step();
    check("loop_pc",    PC, 32'd16);
    check("loop_count", 32'(BRANCH_COUNT), 32'd5);
    for (int i = 0; i < 250; i++) step();
    check("sat_reach", 32'(BRANCH_COUNT), 32'hFF);
    for (int i = 0; i < 3; i++) step();
    check("sat_hold",  32'(BRANCH_COUNT), 32'hFF);
    check("sat_pc",    PC, 32'd16);

    // BNE held off by BUSYWAIT at PC=4
    do_reset();
    INSTRUCTION = ins(OP_NOP, 8'h00);
    TAKEN = 1'b0;
    step();
    INSTRUCTION = ins(OP_BNE, 8'h02);
    TAKEN = 1'b1;
    BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_strobes("bne_busy", 1'b0, 1'b0, 1'b0);
      step();
      check("bne_busy_pc", PC, 32'd4);
    end
    BUSYWAIT = 1'b0;
    check_strobes("bne_stall_rel", 1'b0, 1'b0, 1'b0);
    step();
    check("bne_rel_pc", PC, 32'd4);
    check_strobes("bne_run", 1'b0, 1'b0, 1'b1);
    step();
    check("bne_taken_pc", PC, 32'd16);
    check("bne_count",    32'(BRANCH_COUNT), 32'd1);

    // HALT at PC=20
    INSTRUCTION = ins(OP_NOP, 8'h00);
    TAKEN = 1'b0;
    step();
    INSTRUCTION = ins(OP_HALT, 8'h00);
    #1;
    check("halt_pre", 32'(HALTED), 32'h0);
    step();
    check("halt_set", 32'(HALTED), 32'h1);
    check("halt_pc",  PC, 32'd20);
    INSTRUCTION = ins(OP_J, 8'h10);
    for (int i = 0; i < 5; i++) begin
      TAKEN = ~TAKEN;
      check_strobes("halt", 1'b0, 1'b0, 1'b0);
      step();
      check("halt_frozen_pc", PC, 32'd20);
    end
    check("halt_count", 32'(BRANCH_COUNT), 32'd1);
    check("halt_still", 32'(HALTED), 32'h1);
    TAKEN = 1'b0;
    do_reset();
    check("halt_rst_pc",     PC, 32'h0);
    check("halt_rst_halted", 32'(HALTED), 32'h0);

    // Reset during STALL at PC=40 (jump 0 -> 36, then one step)
    INSTRUCTION = ins(OP_J, 8'h08);
    TAKEN = 1'b1;
    step();
    check("stall_j_pc", PC, 32'd36);
    INSTRUCTION = ins(OP_NOP, 8'h00);
    TAKEN = 1'b0;
    step();
    BUSYWAIT = 1'b1;
    step();
    check("stall_pc", PC, 32'd40);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    BUSYWAIT = 1'b0;
    check("stall_rst_pc",    PC, 32'h0);
    check("stall_rst_count", 32'(BRANCH_COUNT), 32'h0);
    step();
    check("stall_rst_run", PC, 32'd4);

    // Wrap: 4+4-12 = 0xFFFFFFFC, then +4 -> 0
    INSTRUCTION = ins(OP_J, 8'hFD);
    TAKEN = 1'b1;
    step();
    check("wrap_target", PC, 32'hFFFF_FFFC);
    INSTRUCTION = ins(OP_NOP, 8'h00);
    TAKEN = 1'b0;
    step();
    check("wrap_pc", PC, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
